// File: rtl/uart_packet_rx.sv
// UART packet deframer: parses sync/dest/src/len/data byte frames into a beat stream,
// aborting and resynchronising on zero-length frames or inter-byte stalls.

package uart_packet_rx_pkg;

    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic [7:0] Data;
        logic       SoP;
        logic       EoP;
        logic       Valid;
    } uart_packet_t;

endpackage

module uart_packet_rx
    import uart_packet_rx_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = 8'h55,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic         ipClk,
    input  logic         ipReset,
    input  logic [7:0]   ipRxData,
    input  logic         ipRxValid,
    output uart_packet_t opRxStream,
    output logic         opError,
    output logic [15:0]  opPacketCount
);

    localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYCLES + 1);
    // Abort on the idle cycle that would take the counter to TIMEOUT_CYCLES.
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StDest = 3'd1;
    localparam logic [2:0] StSrc  = 3'd2;
    localparam logic [2:0] StLen  = 3'd3;
    localparam logic [2:0] StData = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [7:0]      remain_q, remain_d;
    logic            first_q, first_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    uart_packet_t    stream_q, stream_d;
    logic            error_q, error_d;
    logic [15:0]     count_q, count_d;

    always_comb begin
        state_d        = state_q;
        remain_d       = remain_q;
        first_d        = first_q;
        tmo_d          = tmo_q;
        stream_d       = stream_q;
        stream_d.SoP   = 1'b0;
        stream_d.EoP   = 1'b0;
        stream_d.Valid = 1'b0;
        error_d        = 1'b0;
        count_d        = count_q;

        if (ipRxValid) begin
            // An arriving byte always beats a pending timeout.
            tmo_d = '0;
            case (state_q)
                StIdle: begin
                    if (ipRxData == SYNC_BYTE) begin
                        state_d = StDest;
                    end
                end
                StDest: begin
                    stream_d.Destination = ipRxData;
                    state_d              = StSrc;
                end
                StSrc: begin
                    stream_d.Source = ipRxData;
                    state_d         = StLen;
                end
                StLen: begin
                    if (ipRxData == 8'd0) begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        stream_d.Length = ipRxData;
                        remain_d        = ipRxData;
                        first_d         = 1'b1;
                        state_d         = StData;
                    end
                end
                StData: begin
                    stream_d.Data  = ipRxData;
                    stream_d.Valid = 1'b1;
                    stream_d.SoP   = first_q;
                    first_d        = 1'b0;
                    remain_d       = remain_q - 8'd1;
                    if (remain_q == 8'd1) begin
                        stream_d.EoP = 1'b1;
                        count_d      = count_q + 16'd1;
                        state_d      = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end else if (state_q != StIdle) begin
            if (tmo_q == TmoLast) begin
                error_d = 1'b1;
                state_d = StIdle;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TmoW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state_q  <= StIdle;
            remain_q <= 8'd0;
            first_q  <= 1'b0;
            tmo_q    <= '0;
            stream_q <= '0;
            error_q  <= 1'b0;
            count_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            first_q  <= first_d;
            tmo_q    <= tmo_d;
            stream_q <= stream_d;
            error_q  <= error_d;
            count_q  <= count_d;
        end
    end

    assign opRxStream    = stream_q;
    assign opError       = error_q;
    assign opPacketCount = count_q;

    // Frame markers only ever ride on a valid beat, and an abort never coincides with one.
    assert property (@(posedge ipClk) disable iff (!ipReset)
        (opRxStream.SoP || opRxStream.EoP) |-> opRxStream.Valid);
    assert property (@(posedge ipClk) disable iff (!ipReset)
        !(opError && opRxStream.Valid));

endmodule

// File: tb/tb_uart_packet_rx.sv
// Bench for uart_packet_rx: directed frames plus randomized frame mixes, scored against
// expected beats derived from the frame contents the bench itself generates.

module tb_uart_packet_rx;
    import uart_packet_rx_pkg::*;

    localparam int unsigned Timeout = 100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    uart_packet_t stream;
    logic         err;
    logic [15:0]  cnt;

    always #5 clk = ~clk;

    uart_packet_rx #(
        .SYNC_BYTE      (8'h55),
        .TIMEOUT_CYCLES (Timeout)
    ) dut (
        .ipClk         (clk),
        .ipReset       (rst_n),
        .ipRxData      (rx_data),
        .ipRxValid     (rx_valid),
        .opRxStream    (stream),
        .opError       (err),
        .opPacketCount (cnt)
    );

    int           total = 0;
    int           bad = 0;
    int           exp_err = 0;
    int           err_seen = 0;
    logic [15:0]  exp_count = 16'd0;
    uart_packet_t exp_q[$];
    logic [7:0]   pay[$];
    bit           mon_prev_err = 1'b0;

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends a frame carrying the first nsend bytes of pay and records what should come out.
    task automatic send_frame(input logic [7:0] dst, input logic [7:0] src, input logic [7:0] len,
                              input int nsend, input int gap_max);
        uart_packet_t e;
        send(8'h55);
        idle(int'($urandom_range(gap_max, 0)));
        send(dst);
        idle(int'($urandom_range(gap_max, 0)));
        send(src);
        idle(int'($urandom_range(gap_max, 0)));
        if (len == 8'd0) exp_err++;
        send(len);
        for (int i = 0; i < nsend; i++) begin
            e = '{Source: src, Destination: dst, Length: len, Data: pay[i],
                  SoP: (i == 0), EoP: (i == int'(len) - 1), Valid: 1'b1};
            exp_q.push_back(e);
            idle(int'($urandom_range(gap_max, 0)));
            send(pay[i]);
        end
        if (len != 8'd0 && nsend == int'(len)) exp_count++;
    endtask

    task automatic monitor_beats();
        uart_packet_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                total++;
                if (stream.Valid) begin
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL beat_unexpected got=%h want=none", stream);
                    end else begin
                        e = exp_q.pop_front();
                        if (stream !== e) begin
                            bad++;
                            $display("FAIL beat got=%h want=%h", stream, e);
                        end
                    end
                end else if (stream.SoP !== 1'b0 || stream.EoP !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_markers got sop=%b eop=%b want 0 0", stream.SoP, stream.EoP);
                end
                if (err) begin
                    err_seen++;
                    total++;
                    if (mon_prev_err) begin
                        bad++;
                        $display("FAIL error_width got=2+ cycles want=1");
                    end
                end
                mon_prev_err = err;
            end else begin
                mon_prev_err = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(2);
        total++;
        if (stream !== '0) begin bad++; $display("FAIL reset_stream got=%h want=0", stream); end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", err); end
        total++;
        if (cnt !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", cnt); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_single();
        pay = '{8'h14};
        send_frame(8'hC8, 8'h64, 8'd1, 1, 0);
        total++;
        if (stream.Valid !== 1'b1 || stream.SoP !== 1'b1 || stream.EoP !== 1'b1 ||
            stream.Destination !== 8'd200 || stream.Source !== 8'd100 ||
            stream.Length !== 8'd1 || stream.Data !== 8'h14) begin
            bad++;
            $display("FAIL single_beat got=%h want dst=c8 src=64 len=01 data=14 sop=eop=valid=1",
                     stream);
        end
        total++;
        if (cnt !== 16'd1) begin bad++; $display("FAIL single_count got=%0d want=1", cnt); end
        idle(1);
        total++;
        if (stream.Valid !== 1'b0 || stream.Destination !== 8'hC8 || stream.Source !== 8'h64) begin
            bad++;
            $display("FAIL single_hold got=%h want valid=0 dst=c8 src=64", stream);
        end
        idle(2);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL single_pending got=%0d want=0", exp_q.size()); exp_q.delete(); end
        total++;
        if (err_seen != exp_err) begin bad++; $display("FAIL single_errors got=%0d want=%0d", err_seen, exp_err); end
    endtask

    task automatic test_multi();
        pay = '{8'hAA, 8'h55, 8'hBB};
        send_frame(8'h02, 8'h03, 8'd3, 3, 0);
        idle(3);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL multi_pending got=%0d want=0", exp_q.size()); exp_q.delete(); end
        total++;
        if (err_seen != exp_err) begin bad++; $display("FAIL multi_errors got=%0d want=%0d", err_seen, exp_err); end
        total++;
        if (cnt !== exp_count) begin bad++; $display("FAIL multi_count got=%0d want=%0d", cnt, exp_count); end
    endtask

    task automatic test_garbage();
        send(8'h00);
        send(8'hFF);
        idle(2);
        send(8'h13);
        pay = '{8'h10, 8'h20};
        send_frame(8'h01, 8'h02, 8'd2, 2, 1);
        idle(3);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL garbage_pending got=%0d want=0", exp_q.size()); exp_q.delete(); end
        total++;
        if (err_seen != exp_err) begin bad++; $display("FAIL garbage_errors got=%0d want=%0d", err_seen, exp_err); end
        total++;
        if (cnt !== exp_count) begin bad++; $display("FAIL garbage_count got=%0d want=%0d", cnt, exp_count); end
    endtask

    task automatic test_len_zero();
        send_frame(8'h01, 8'h02, 8'd0, 0, 0);
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL len0_pulse got=%b want=1", err); end
        idle(3);
        pay = '{8'h5A};
        send_frame(8'h03, 8'h04, 8'd1, 1, 0);
        idle(3);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL len0_pending got=%0d want=0", exp_q.size()); exp_q.delete(); end
        total++;
        if (err_seen != exp_err) begin bad++; $display("FAIL len0_errors got=%0d want=%0d", err_seen, exp_err); end
        total++;
        if (cnt !== exp_count) begin bad++; $display("FAIL len0_count got=%0d want=%0d", cnt, exp_count); end
    endtask

    task automatic test_timeout();
        uart_packet_t e;
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(8'h01, 8'h02, 8'd4, 2, 0);
        idle(Timeout - 1);
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b want=0 at cycle 99", err); end
        idle(1);
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL timeout_pulse got=%b want=1 at cycle 100", err); end
        exp_err++;
        idle(3);
        // Late byte 99 cycles after the previous one must be accepted.
        pay = '{8'hA1, 8'hA2};
        send_frame(8'h03, 8'h04, 8'd2, 1, 0);
        e = '{Source: 8'h04, Destination: 8'h03, Length: 8'd2, Data: 8'hA2,
              SoP: 1'b0, EoP: 1'b1, Valid: 1'b1};
        exp_q.push_back(e);
        idle(Timeout - 2);
        send(8'hA2);
        exp_count++;
        // Bytes landing exactly on the limit cycle win over the timeout.
        send(8'h55);
        idle(Timeout - 1);
        send(8'h05);
        idle(Timeout - 1);
        send(8'h06);
        idle(Timeout - 1);
        send(8'h01);
        e = '{Source: 8'h06, Destination: 8'h05, Length: 8'd1, Data: 8'h77,
              SoP: 1'b1, EoP: 1'b1, Valid: 1'b1};
        exp_q.push_back(e);
        idle(Timeout - 1);
        send(8'h77);
        exp_count++;
        idle(3);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL timeout_pending got=%0d want=0", exp_q.size()); exp_q.delete(); end
        total++;
        if (err_seen != exp_err) begin bad++; $display("FAIL timeout_errors got=%0d want=%0d", err_seen, exp_err); end
        total++;
        if (cnt !== exp_count) begin bad++; $display("FAIL timeout_count got=%0d want=%0d", cnt, exp_count); end
    endtask

    task automatic test_back_to_back();
        pay = '{8'h01, 8'h02};
        send_frame(8'h10, 8'h20, 8'd2, 2, 0);
        pay = '{8'h55};
        send_frame(8'h30, 8'h40, 8'd1, 1, 0);
        pay = '{8'hE0, 8'hE1, 8'hE2};
        send_frame(8'h50, 8'h60, 8'd3, 3, 0);
        idle(3);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_pending got=%0d want=0", exp_q.size()); exp_q.delete(); end
        total++;
        if (err_seen != exp_err) begin bad++; $display("FAIL b2b_errors got=%0d want=%0d", err_seen, exp_err); end
        total++;
        if (cnt !== exp_count) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", cnt, exp_count); end
    endtask

    task automatic test_async_reset();
        pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        send_frame(8'h0A, 8'h0B, 8'd5, 2, 1);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (stream !== '0) begin bad++; $display("FAIL areset_stream got=%h want=0", stream); end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL areset_error got=%b want=0", err); end
        total++;
        if (cnt !== 16'd0) begin bad++; $display("FAIL areset_count got=%0d want=0", cnt); end
        exp_count = 16'd0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        pay = '{8'h14};
        send_frame(8'hC8, 8'h64, 8'd1, 1, 0);
        idle(3);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL areset_pending got=%0d want=0", exp_q.size()); exp_q.delete(); end
        total++;
        if (err_seen != exp_err) begin bad++; $display("FAIL areset_errors got=%0d want=%0d", err_seen, exp_err); end
        total++;
        if (cnt !== exp_count) begin bad++; $display("FAIL areset_count_after got=%0d want=%0d", cnt, exp_count); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [7:0] len;
        int         kind;
        int         nsend;
        for (int f = 0; f < 40; f++) begin
            for (int g = 0; g < int'($urandom_range(3, 0)); g++) begin
                b = 8'($urandom);
                if (b == 8'h55) b = 8'h56;
                send(b);
                idle(int'($urandom_range(2, 0)));
            end
            kind = int'($urandom_range(9, 0));
            len  = (kind == 0) ? 8'd0 : 8'($urandom_range(12, 1));
            pay.delete();
            for (int i = 0; i < int'(len); i++) pay.push_back(8'($urandom));
            nsend = (kind == 1) ? int'($urandom_range(int'(len) - 1, 0)) : int'(len);
            send_frame(8'($urandom), 8'($urandom), len, nsend, 3);
            if (kind == 1) begin
                idle(Timeout + 2);
                exp_err++;
            end
            idle(int'($urandom_range(3, 0)));
        end
        idle(3);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL random_pending got=%0d want=0", exp_q.size()); exp_q.delete(); end
        total++;
        if (err_seen != exp_err) begin bad++; $display("FAIL random_errors got=%0d want=%0d", err_seen, exp_err); end
        total++;
        if (cnt !== exp_count) begin bad++; $display("FAIL random_count got=%0d want=%0d", cnt, exp_count); end
    endtask

    initial begin
        fork
            monitor_beats();
        join_none
        test_reset();
        test_single();
        test_multi();
        test_garbage();
        test_len_zero();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog got=still running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
